// File: rtl/dvp_frame_tx_if.sv
// dvp_frame_tx_if: control handshake, frame-buffer read port and DVP bus.
// Ports: master = transmitter side (drives BUSY/DONE/RAM_RADDR/DVP_*), slave = environment side.
interface dvp_frame_tx_if #(
    parameter int ADDR_W = 17
);
    logic              START;
    logic              ABORT;
    logic              BUSY;
    logic              DONE;
    logic [ADDR_W-1:0] RAM_RADDR;
    logic [31:0]       RAM_RDATA;
    logic              DVP_PCLK;
    logic              DVP_VSYNC;
    logic              DVP_HREF;
    logic [7:0]        DVP_DATA;

    modport master (
        input  START, ABORT, RAM_RDATA,
        output BUSY, DONE, RAM_RADDR,
        output DVP_PCLK, DVP_VSYNC, DVP_HREF, DVP_DATA
    );

    modport slave (
        output START, ABORT, RAM_RDATA,
        input  BUSY, DONE, RAM_RADDR,
        input  DVP_PCLK, DVP_VSYNC, DVP_HREF, DVP_DATA
    );
endinterface

// File: rtl/dvp_frame_tx.sv
// dvp_frame_tx: reads RGB565 pixels from a frame buffer and serialises them as DVP bytes.
// Ports: HCLK, HRESET (async, active-high); bus = START/ABORT/BUSY/DONE, RAM read port, DVP outputs.
module dvp_frame_tx #(
    parameter int H_ACTIVE  = 320,
    parameter int V_ACTIVE  = 240,
    parameter int H_BLANK   = 16,
    parameter int VS_LINES  = 2,
    parameter int VBP_LINES = 2,
    parameter int VFP_LINES = 2,
    parameter int CLK_DIV   = 2,
    parameter int ADDR_W    = 17
) (
    input  logic           HCLK,
    input  logic           HRESET,
    dvp_frame_tx_if.master bus
);
    localparam int LINE_BYTES = 2 * H_ACTIVE + H_BLANK;
    localparam int ACT_BYTES  = 2 * H_ACTIVE;
    localparam int MAX_A      = (VS_LINES > VBP_LINES) ? VS_LINES : VBP_LINES;
    localparam int MAX_B      = (V_ACTIVE > VFP_LINES) ? V_ACTIVE : VFP_LINES;
    localparam int MAX_L      = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int DIV_W      = $clog2(CLK_DIV);
    localparam int BYTE_W     = $clog2(LINE_BYTES);
    localparam int LINE_W     = (MAX_L > 1) ? $clog2(MAX_L) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_VS,
        S_VBP,
        S_ACT,
        S_VFP
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [BYTE_W-1:0]   byte_q, byte_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [LINE_W-1:0]   phase_last;
    logic                pclk_q, pclk_d;
    logic                vsync_q, vsync_d;
    logic                href_q, href_d;
    logic [7:0]          data_q, data_d;
    logic [7:0]          pix_lo_q, pix_lo_d;
    logic [ADDR_W-1:0]   raddr_q, raddr_d;
    logic                done_q, done_d;
    logic                abort_q, abort_d;
    logic                boundary;
    logic                abort_req;
    logic                last_byte;
    logic                last_line;
    logic                unused_rdata;

    assign unused_rdata = ^bus.RAM_RDATA[31:16];

    always_comb begin
        state_d    = state_q;
        byte_d     = byte_q;
        line_d     = line_q;
        vsync_d    = vsync_q;
        href_d     = href_q;
        data_d     = data_q;
        pix_lo_d   = pix_lo_q;
        raddr_d    = raddr_q;
        done_d     = 1'b0;
        phase_last = '0;
        boundary   = (div_q == DIV_W'(CLK_DIV - 1));
        div_d      = boundary ? '0 : div_q + 1'b1;
        pclk_d     = (div_d >= DIV_W'(CLK_DIV / 2));
        // A short ABORT between boundaries is held until the next one.
        abort_req  = (bus.ABORT | abort_q) & (state_q != S_IDLE);
        abort_d    = boundary ? 1'b0 : abort_req;

        unique case (state_q)
            S_VS:    phase_last = LINE_W'(VS_LINES - 1);
            S_VBP:   phase_last = LINE_W'(VBP_LINES - 1);
            S_ACT:   phase_last = LINE_W'(V_ACTIVE - 1);
            S_VFP:   phase_last = LINE_W'(VFP_LINES - 1);
            default: phase_last = '0;
        endcase
        last_byte = (byte_q == BYTE_W'(LINE_BYTES - 1));
        last_line = (line_q == phase_last);

        if (boundary) begin
            if (abort_req) begin
                state_d = S_IDLE;
                byte_d  = '0;
                line_d  = '0;
            end else if (state_q == S_IDLE) begin
                if (bus.START) begin
                    state_d = S_VS;
                    byte_d  = '0;
                    line_d  = '0;
                end
            end else begin
                byte_d = last_byte ? '0 : byte_q + 1'b1;
                if (last_byte) begin
                    line_d = last_line ? '0 : line_q + 1'b1;
                    if (last_line) begin
                        unique case (state_q)
                            S_VS:  state_d = S_VBP;
                            S_VBP: state_d = S_ACT;
                            S_ACT: state_d = S_VFP;
                            default: begin
                                state_d = S_IDLE;
                                done_d  = 1'b1;
                            end
                        endcase
                    end
                end
            end

            // Outputs describe the byte period that starts at this boundary.
            vsync_d = (state_d == S_IDLE) || (state_d == S_VS);
            href_d  = (state_d == S_ACT) && (byte_d < BYTE_W'(ACT_BYTES));
            data_d  = '0;
            if (href_d) begin
                if (!byte_d[0]) begin
                    // RAM_RADDR already points here; data arrived a cycle ago.
                    data_d   = bus.RAM_RDATA[15:8];
                    pix_lo_d = bus.RAM_RDATA[7:0];
                    raddr_d  = raddr_q + 1'b1;
                end else begin
                    data_d = pix_lo_q;
                end
            end
            if (state_d == S_IDLE) begin
                raddr_d = '0;
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q  <= S_IDLE;
            div_q    <= '0;
            byte_q   <= '0;
            line_q   <= '0;
            pclk_q   <= 1'b0;
            vsync_q  <= 1'b1;
            href_q   <= 1'b0;
            data_q   <= '0;
            pix_lo_q <= '0;
            raddr_q  <= '0;
            done_q   <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            byte_q   <= byte_d;
            line_q   <= line_d;
            pclk_q   <= pclk_d;
            vsync_q  <= vsync_d;
            href_q   <= href_d;
            data_q   <= data_d;
            pix_lo_q <= pix_lo_d;
            raddr_q  <= raddr_d;
            done_q   <= done_d;
            abort_q  <= abort_d;
        end
    end

    assign bus.BUSY      = (state_q != S_IDLE);
    assign bus.DONE      = done_q;
    assign bus.RAM_RADDR = raddr_q;
    assign bus.DVP_PCLK  = pclk_q;
    assign bus.DVP_VSYNC = vsync_q;
    assign bus.DVP_HREF  = href_q;
    assign bus.DVP_DATA  = data_q;
endmodule

// File: doc/dvp_frame_tx.md
Name: dvp_frame_tx

Overview:
- Camera-interface transmitter. Reads RGB565 pixels from the frame-buffer dual-port RAM read port and serialises them onto a DVP-style bus: pixel clock, VSYNC, HREF and 8-bit data.
- Byte order and framing match the capture block: high byte first, VSYNC high outside the frame, HREF high only during active bytes.
- Used for frame loopback, display/sensor emulation and self-test of the capture path.

Parameters:
- H_ACTIVE, 320, pixels per active line
- V_ACTIVE, 240, active lines per frame
- H_BLANK, 16, blanking byte periods after active bytes on every line
- VS_LINES, 2, line periods with VSYNC high at frame start
- VBP_LINES, 2, back-porch line periods (VSYNC low, HREF low)
- VFP_LINES, 2, front-porch line periods after last active line
- CLK_DIV, 2, HCLK cycles per byte period; even, >=2
- ADDR_W, 17, RAM word-address width

Ports:
- HCLK  in  1  sole clock
- HRESET  in  1  asynchronous, active-high reset
- START  in  1  request one frame; level, sampled only in IDLE
- ABORT  in  1  terminate the current frame
- BUSY  out  1  high while not in IDLE
- DONE  out  1  one-HCLK pulse on normal frame completion
- RAM_RADDR  out  ADDR_W  frame-buffer word address
- RAM_RDATA  in  32  RAM read data, 1-HCLK latency; pixel in [15:0]
- DVP_PCLK  out  1  byte clock
- DVP_VSYNC  out  1  frame sync, active-high
- DVP_HREF  out  1  line valid
- DVP_DATA  out  8  pixel byte

Behaviour:
- Reset values: DVP_VSYNC=1, DVP_HREF=0, DVP_DATA=0, DVP_PCLK=0, BUSY=0, DONE=0, RAM_RADDR=0. All counters and the FSM go to IDLE.
- Byte timing:
  - A free-running div_cnt counts 0..CLK_DIV-1, also in IDLE.
  - A byte boundary is the HCLK edge where div_cnt wraps to 0.
  - DVP_VSYNC, DVP_HREF and DVP_DATA are registered and change only on byte boundaries.
  - DVP_PCLK is registered: 0 while div_cnt < CLK_DIV/2, else 1. Its rising edge is mid-byte, and the receiver samples there.
- Line structure:
  - LINE_BYTES = 2*H_ACTIVE + H_BLANK byte periods per line.
  - byte_cnt counts 0..LINE_BYTES-1; line_cnt counts lines within the current phase.
- FSM; states advance at byte boundaries only:
  - IDLE: VSYNC=1, HREF=0, DATA=0. START=1 → VSYNC at the next boundary.
  - VSYNC: VSYNC=1 for VS_LINES lines → VBP.
  - VBP: VSYNC=0, HREF=0 for VBP_LINES lines → ACTIVE.
  - ACTIVE, for V_ACTIVE lines:
    - HREF=1 for byte_cnt 0..2*H_ACTIVE-1.
    - Even byte_cnt emits pixel[15:8]; odd byte_cnt emits pixel[7:0].
    - HREF=0 and DATA=0 during the H_BLANK bytes.
    - After the last line → VFP.
  - VFP: HREF=0, VSYNC=0 for VFP_LINES lines, then → IDLE with DONE=1 for exactly one HCLK.
  - The IDLE return drives VSYNC=1, which closes the frame at the receiver.
- RAM prefetch:
  - RAM_RADDR always holds the index of the next pixel to send.
  - On each boundary that starts a high byte:
    - DVP_DATA takes RAM_RDATA[15:8].
    - pix_lo takes RAM_RDATA[7:0].
    - RAM_RADDR increments.
  - CLK_DIV >= 2 guarantees at least 1 HCLK of read latency.
  - Pixel index runs 0..H_ACTIVE*V_ACTIVE-1, linear and row-major across lines.
  - RAM_RADDR returns to 0 on entry to IDLE, whether by DONE, ABORT or reset.
- Handshake:
  - BUSY rises on the boundary that leaves IDLE.
  - START is ignored while BUSY=1. START held high produces back-to-back frames, each with its own VSYNC phase.
  - START in the same cycle as DONE is ignored; START on the following cycle is accepted.
- ABORT: in any non-IDLE state, the FSM enters IDLE at the next byte boundary: VSYNC=1, HREF=0, DATA=0, RAM_RADDR=0, no DONE. ABORT wins over START. ABORT in IDLE has no effect.
- Reset mid-frame: all outputs return to reset values immediately (asynchronous).
- Width rules:
  - Counters are wide enough for their maximum count.
  - RAM_RADDR wraps modulo 2^ADDR_W. H_ACTIVE*V_ACTIVE <= 2^ADDR_W is a configuration requirement.
  - RAM_RDATA[31:16] is ignored.

Test Plan:
Common setup: H_ACTIVE=4, V_ACTIVE=2, H_BLANK=2, VS_LINES=1, VBP_LINES=1, VFP_LINES=1, CLK_DIV=2. The RAM model returns word n = 32'h0000_A000+n.
- Single frame: START pulse →
  - DVP_DATA sequence while HREF=1 is A0,00,A0,01,A0,02,A0,03 on line 0 and A0,04..A0,07 on line 1.
  - HREF high for 8 byte periods per line, 16 total.
  - VSYNC low for 40 byte periods.
  - DONE one cycle after 50 byte periods (100 HCLK); RAM_RADDR back to 0.
- Timing check:
  - DVP_PCLK period is 2 HCLK.
  - Data, HREF and VSYNC never change within 1 HCLK before a PCLK rising edge.
  - VSYNC=1 throughout IDLE.
- START held high → two consecutive frames with identical data. BUSY stays 1 except in the single DONE cycle, and DONE pulses twice.
- ABORT during line 1 at byte_cnt 3 → next boundary gives VSYNC=1, HREF=0, RAM_RADDR=0; DONE never asserts; BUSY falls.
- HRESET asserted mid-ACTIVE → all outputs at reset values within the same cycle. A new START after release yields a full frame that restarts at A0,00.
- Loopback into the camera capture block with the same parameters → captured RAM contents equal the source words [15:0] for n=0..7.
